// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: bus bundle between the RAM arbiter, its three requesters and the RAM port
// slave  : arbiter side (takes requests and RAM status, drives waits, read data and RAM controls)
// master : environment side (drives requests and RAM status, observes waits and RAM controls)
interface mem_arbiter_if #(parameter int WORD_W = 32);
  logic [1:0]             iREN;
  logic [1:0][WORD_W-1:0] iaddr;
  logic [1:0]             iwait;
  logic [1:0][WORD_W-1:0] iload;
  logic                   dREN;
  logic                   dWEN;
  logic [WORD_W-1:0]      daddr;
  logic [WORD_W-1:0]      dstore;
  logic                   dwait;
  logic [WORD_W-1:0]      dload;
  logic                   ramREN;
  logic                   ramWEN;
  logic [WORD_W-1:0]      ramaddr;
  logic [WORD_W-1:0]      ramstore;
  logic [WORD_W-1:0]      ramload;
  logic [1:0]             ramstate;
  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  iwait, iload, dwait, dload, ramREN, ramWEN, ramaddr, ramstore
  );
endinterface

// File: rtl/mem_arbiter.sv
// mem_arbiter: single RAM port shared by two instruction fetchers (round-robin) and a data channel (priority)
// Ports: CLK, RST (sync, active-high), bus (mem_arbiter_if.slave: requests, waits, read data, RAM controls)
// Optional: MEM_ARB_STARVE_EN adds a counter that forces an instruction grant after IMAX_WAIT data grants
module mem_arbiter #(
  parameter int WORD_W    = 32,
  parameter int IMAX_WAIT = 4
) (
  input logic          CLK,
  input logic          RST,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DATA, INSTR} state_t;
  state_t st_q, st_d;
  logic gcore_q, gcore_d, rr_q, rr_d;
  logic acc, dreq, ireq, live, d_done, i_done, starve;
  assign acc    = bus.ramstate == 2'd2;
  assign dreq   = bus.dREN | bus.dWEN;
  assign ireq   = |bus.iREN;
  // a grant stays live only while its requester keeps asking; otherwise it is aborted
  assign live   = (st_q == DATA && dreq) || (st_q == INSTR && bus.iREN[gcore_q]);
  assign d_done = st_q == DATA && dreq && acc;
  assign i_done = st_q == INSTR && bus.iREN[gcore_q] && acc;
`ifdef MEM_ARB_STARVE_EN
  localparam int CW = $clog2(IMAX_WAIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  always_comb begin
    cnt_d = cnt_q;
    if ((st_q == IDLE && !ireq) || i_done) cnt_d = '0;
    else if (d_done && ireq && cnt_q != CW'(IMAX_WAIT)) cnt_d = cnt_q + 1'b1;
  end
  always_ff @(posedge CLK) cnt_q <= RST ? '0 : cnt_d;
  assign starve = cnt_q == CW'(IMAX_WAIT);
`else
  logic unused_imax;
  assign unused_imax = ^IMAX_WAIT;
  assign starve      = 1'b0;
`endif
  always_comb begin
    st_d    = st_q;
    gcore_d = gcore_q;
    rr_d    = i_done ? ~gcore_q : rr_q;
    if (st_q == IDLE) begin
      if (ireq && (starve || !dreq)) begin
        st_d    = INSTR;
        gcore_d = bus.iREN[rr_q] ? rr_q : ~rr_q;
      end else if (dreq) st_d = DATA;
    end else if (!live || acc) st_d = IDLE;
  end
  always_ff @(posedge CLK) begin
    if (RST) begin
      st_q    <= IDLE;
      gcore_q <= 1'b0;
      rr_q    <= 1'b0;
    end else begin
      st_q    <= st_d;
      gcore_q <= gcore_d;
      rr_q    <= rr_d;
    end
  end
  // enables follow the live request so an abort drops them in the same cycle
  assign bus.ramWEN   = st_q == DATA && bus.dWEN;
  assign bus.ramREN   = (st_q == DATA && bus.dREN && !bus.dWEN) || (st_q == INSTR && bus.iREN[gcore_q]);
  assign bus.ramaddr  = st_q == DATA ? bus.daddr : st_q == INSTR ? bus.iaddr[gcore_q] : {WORD_W{1'b0}};
  assign bus.ramstore = st_q == DATA ? bus.dstore : {WORD_W{1'b0}};
  assign bus.dwait    = ~d_done;
  assign bus.iwait    = ~({1'b0, i_done} << gcore_q);
  assign bus.dload    = bus.ramload;
  assign bus.iload    = {2{bus.ramload}};
endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbitrates the single RAM port between the two cores' instruction caches and the coherence bus data channel. Data traffic from the bus controller is serviced ahead of instruction fetches. Instruction fetches from core 0 and core 1 alternate round-robin. The block holds one registered grant until the RAM reports ACCESS, then returns to idle and re-arbitrates.

## Interface
Parameters:
- WORD_W, 32, width of addresses and data words
- IMAX_WAIT, 4, consecutive data grants tolerated while an instruction fetch waits (used only with the starvation guard)

Ports:
- CLK  in  1  clock, rising edge
- RST  in  1  reset; synchronous, active-high
- iREN  in  2  instruction read request, one bit per core
- iaddr  in  2xWORD_W  instruction address per core
- iwait  out  2  instruction wait per core; low in the completing cycle only
- iload  out  2xWORD_W  instruction read data per core
- dREN  in  1  data read request from the bus controller
- dWEN  in  1  data write request from the bus controller
- daddr  in  WORD_W  data address
- dstore  in  WORD_W  data write value
- dwait  out  1  data wait; low in the completing cycle only
- dload  out  WORD_W  data read value
- ramREN  out  1  RAM read enable
- ramWEN  out  1  RAM write enable
- ramaddr  out  WORD_W  RAM address
- ramstore  out  WORD_W  RAM write data
- ramload  in  WORD_W  RAM read data
- ramstate  in  2  RAM status: FREE=0, BUSY=1, ACCESS=2, ERROR=3

## Operation
- FSM states: IDLE, DATA, INSTR. Grant registers: gstate, gcore (1 bit), and rr pointer (1 bit).
- IDLE
  - If dREN or dWEN is high, go to DATA.
  - Otherwise, if any iREN is high, go to INSTR. gcore is rr when iREN[rr] is set, else the other core.
  - Otherwise, stay in IDLE.
- DATA
  - ramaddr=daddr, ramstore=dstore.
  - If dWEN is high, ramWEN=1 and ramREN=0. dWEN wins when dREN and dWEN are both high.
  - Otherwise, ramREN=1.
- INSTR
  - ramREN=1, ramaddr=iaddr[gcore], ramstore=0.
- Completion: ramstate==ACCESS while in DATA or INSTR.
  - The granted wait goes low in the same cycle.
  - The FSM goes to IDLE on the next edge.
  - An INSTR completion sets rr to ~gcore.
- ERROR and BUSY: the FSM holds its state and keeps the wait high. The access is retried until ACCESS.
- Abort: if the granted request drops before completion (DATA: dREN and dWEN both low; INSTR: iREN[gcore] low):
  - RAM enables drop combinationally in that cycle.
  - The FSM goes to IDLE on the next edge.
  - No wait goes low and rr is unchanged.
- Read data:
  - dload = ramload at all times.
  - iload[n] = ramload at all times.
  - Requesters sample the data only in the cycle their wait is low.
- All waits not being completed stay high.

## Timing
- Reset, effective at the first rising CLK edge with RST high:
  - state=IDLE, rr=0, gcore=0, starvation count=0.
  - Outputs: iwait=2'b11, dwait=1, ramREN=0, ramWEN=0, ramaddr=0, ramstore=0.
- In IDLE: every wait output is high, ramREN=0, ramWEN=0, ramaddr=0.
- Latency:
  - Request seen high in IDLE at edge t: RAM enables asserted from t+1.
  - If ramstate==ACCESS in that cycle, the wait is low in the cycle after edge t.
  - Minimum request-to-done time is 2 cycles, plus 1 IDLE bubble cycle between back-to-back grants.
- Requesters must hold address and data stable until their wait goes low.
- Reset asserted mid-transaction: the access is abandoned with no completion pulse and all outputs return to their reset values.
- Simultaneous dREN/dWEN and iREN in IDLE: data wins, unless the starvation guard forces an instruction grant.

## Configuration
- Macro: MEM_ARB_STARVE_EN.
- Defined: a starvation counter is compiled in.
  - It increments on each DATA completion while any iREN is high.
  - It clears on an INSTR completion, or in any IDLE cycle with iREN==0.
  - When the count equals IMAX_WAIT, IDLE grants INSTR even if data is pending.
  - The counter saturates at IMAX_WAIT.
- Undefined: no counter; strict data priority. Instruction fetches may starve indefinitely.

## Test plan
- Reset: hold RST for 2 cycles -> iwait=11, dwait=1, ramREN=ramWEN=0, ramaddr=0.
- Single fetch: iREN=01, iaddr[0]=0x40, ramstate=ACCESS -> ramREN=1 and ramaddr=0x40 one cycle later; iwait=10 in that cycle; iload[0]=ramload.
- Data priority: dWEN=1 (daddr=0x100, dstore=0xDEADBEEF) together with iREN=11 -> DATA granted first with ramWEN=1; then core 0 fetches, then core 1, each separated by one IDLE cycle.
- RAM stall and error: ramstate=BUSY for 3 cycles, then ERROR for 1, then ACCESS -> dwait stays high for 4 cycles and goes low on the ACCESS cycle.
- Abort: drop iREN[1] during a BUSY cycle -> ramREN=0 in the same cycle, IDLE next, rr unchanged, no iwait pulse.
- Starvation (macro defined, IMAX_WAIT=4): continuous dREN with iREN=01 -> INSTR granted after the 4th DATA completion. With the macro undefined -> no INSTR grant.
